// File: rtl/r_rob_pkg.sv
// Shared types and constants for the read-response ordering unit and its
// response memory: uid geometry, beat payload and AXI response codes.
package r_rob_pkg;

  localparam int ID_WIDTH_DEF   = 32;
  localparam int NUM_ROWS_DEF   = 16;
  localparam int NUM_COLS_DEF   = 16;
  localparam int MAX_LEN_DEF    = 8;
  localparam int POOL_DEPTH_DEF = 64;

  localparam int ROW_W = $clog2(NUM_ROWS_DEF);
  localparam int COL_W = $clog2(NUM_COLS_DEF);
  localparam int UID_W = ROW_W + COL_W;
  localparam int IDX_W = $clog2(POOL_DEPTH_DEF);
  localparam int CNT_W = $clog2(POOL_DEPTH_DEF + 1);

  localparam int DATA_W = 32;
  localparam int RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef logic [UID_W-1:0] uid_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;
  } beat_t;

endpackage

// File: rtl/rm_free_list.sv
// Free-index FIFO for the response memory beat pool. Preloaded with every
// index at reset; a pop and a push may happen in the same cycle.
module rm_free_list #(
  parameter int DEPTH = 64,
  parameter int IW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pop_i,
  input  logic          push_i,
  input  logic [IW-1:0] push_idx_i,
  output logic [IW-1:0] pop_idx_o,
  output logic [CW-1:0] free_cnt_o
);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] rd_q, wr_q, rd_d, wr_d;
  logic [CW-1:0] cnt_q;

  // Explicit wrap keeps non-power-of-two depths correct.
  assign rd_d = (rd_q == IW'(DEPTH - 1)) ? '0 : rd_q + IW'(1);
  assign wr_d = (wr_q == IW'(DEPTH - 1)) ? '0 : wr_q + IW'(1);

  assign pop_idx_o  = mem_q[rd_q];
  assign free_cnt_o = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= IW'(i);
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= CW'(DEPTH);
    end else begin
      if (pop_i) rd_q <= rd_d;
      if (push_i) begin
        mem_q[wr_q] <= push_idx_i;
        wr_q        <= wr_d;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/r_response_memory.sv
// Linked-list response memory: parks read-response beats per uid in a shared
// pool and presents each uid's oldest beat. Optional checks: R_RM_PROTOCOL_CHECK_EN.
module r_response_memory
  import r_rob_pkg::*;
#(
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int NUM_ROWS   = NUM_ROWS_DEF,
  parameter int NUM_COLS   = NUM_COLS_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int POOL_DEPTH = POOL_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                r_store_valid_i,
  output logic                r_store_ready_o,
  input  logic [ID_WIDTH-1:0] r_store_id_i,
  input  logic [DATA_W-1:0]   r_store_data_i,
  input  logic [RESP_W-1:0]   r_store_resp_i,
  input  logic                r_store_last_i,
  input  logic [ID_WIDTH-1:0] rm_release_uid,
  output logic                r_release_valid_o,
  input  logic                r_release_ready_i,
  output logic [ID_WIDTH-1:0] r_release_id_o,
  output logic [DATA_W-1:0]   r_release_data_o,
  output logic [RESP_W-1:0]   r_release_resp_o,
  output logic                r_release_last_o,
  output logic                rm_error
);

  localparam int LUID_W  = $clog2(NUM_ROWS) + $clog2(NUM_COLS);
  localparam int NUM_UID = 1 << LUID_W;
  localparam int LIDX_W  = $clog2(POOL_DEPTH);
  localparam int LCNT_W  = $clog2(POOL_DEPTH + 1);

  // Both channels: a beat transfers on a cycle where valid and ready are both
  // high. valid never looks at ready; store ready uses registered state only.
  logic [LUID_W-1:0] st_uid, rl_uid;
  logic [LIDX_W-1:0] head_q [NUM_UID];
  logic [LIDX_W-1:0] tail_q [NUM_UID];
  logic [LCNT_W-1:0] cnt_q  [NUM_UID];
  logic [LIDX_W-1:0] next_q [POOL_DEPTH];
  beat_t             beat_q [POOL_DEPTH];
  logic              init_done_q;
  logic [LCNT_W-1:0] free_cnt;
  logic [LIDX_W-1:0] free_idx, rl_head;
  logic              st_fire, rl_fire, same_uid, reuse_head;
  logic              unused_rel_hi;

  assign st_uid  = r_store_id_i[LUID_W-1:0];
  assign rl_uid  = rm_release_uid[LUID_W-1:0];
  assign rl_head = head_q[rl_uid];

  assign r_store_ready_o   = init_done_q & (free_cnt != '0);
  assign r_release_valid_o = (cnt_q[rl_uid] != '0);
  assign r_release_id_o    = rm_release_uid;
  assign r_release_data_o  = beat_q[rl_head].data;
  assign r_release_resp_o  = beat_q[rl_head].resp;
  assign r_release_last_o  = beat_q[rl_head].last;

  assign st_fire    = r_store_valid_i & r_store_ready_o;
  assign rl_fire    = r_release_valid_o & r_release_ready_i;
  assign same_uid   = st_fire & rl_fire & (st_uid == rl_uid);
  // The only beat of a uid leaves while a new one arrives: the new entry is the whole list.
  assign reuse_head = same_uid & (cnt_q[st_uid] == LCNT_W'(1));

  assign unused_rel_hi = ^rm_release_uid;

  rm_free_list #(.DEPTH(POOL_DEPTH)) u_free_list (
    .clk        (clk),
    .rst        (rst),
    .pop_i      (st_fire),
    .push_i     (rl_fire),
    .push_idx_i (rl_head),
    .pop_idx_o  (free_idx),
    .free_cnt_o (free_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_done_q <= 1'b0;
      for (int u = 0; u < NUM_UID; u++) cnt_q[u] <= '0;
    end else begin
      init_done_q <= 1'b1;
      if (!same_uid) begin
        if (st_fire) cnt_q[st_uid] <= cnt_q[st_uid] + LCNT_W'(1);
        if (rl_fire) cnt_q[rl_uid] <= cnt_q[rl_uid] - LCNT_W'(1);
      end
    end
  end

  // Links and payload are only meaningful while cnt says so; no reset needed.
  always_ff @(posedge clk) begin
    if (rl_fire) head_q[rl_uid] <= next_q[rl_head];
    if (st_fire) begin
      beat_q[free_idx] <= '{data: r_store_data_i, resp: r_store_resp_i, last: r_store_last_i};
      tail_q[st_uid]   <= free_idx;
      if ((cnt_q[st_uid] == '0) || reuse_head) head_q[st_uid] <= free_idx;
      else next_q[tail_q[st_uid]] <= free_idx;
    end
  end

`ifdef R_RM_PROTOCOL_CHECK_EN
  logic              err_q, id_err, len_err, last_err;
  logic [LCNT_W-1:0] st_cnt_next;

  assign st_cnt_next = same_uid ? cnt_q[st_uid] : cnt_q[st_uid] + LCNT_W'(1);
  assign id_err      = st_fire & ((r_store_id_i >> LUID_W) != '0);
  assign len_err     = st_fire & (st_cnt_next > LCNT_W'(MAX_LEN));
  assign last_err    = st_fire & (cnt_q[st_uid] != '0) & beat_q[tail_q[st_uid]].last & ~reuse_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else if (id_err | len_err | last_err) err_q <= 1'b1;
  end

  assign rm_error = err_q;
`else
  logic unused_store_hi;
  assign unused_store_hi = ^r_store_id_i;
  assign rm_error        = 1'b0;
`endif

endmodule

// File: tb/tb_r_response_memory.sv
// Self-checking bench for r_response_memory: directed scenarios plus random
// traffic against a per-uid queue model of the parked beats.
module tb_r_response_memory;

  localparam int POOL = 64;
  localparam int MAXL = 8;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } mbeat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r_store_valid_i = 1'b0;
  logic        r_store_ready_o;
  logic [31:0] r_store_id_i = '0;
  logic [31:0] r_store_data_i = '0;
  logic [1:0]  r_store_resp_i = '0;
  logic        r_store_last_i = 1'b0;
  logic [31:0] rm_release_uid = '0;
  logic        r_release_valid_o;
  logic        r_release_ready_i = 1'b0;
  logic [31:0] r_release_id_o;
  logic [31:0] r_release_data_o;
  logic [1:0]  r_release_resp_o;
  logic        r_release_last_o;
  logic        rm_error;

  always #5 clk = ~clk;

  r_response_memory dut (
    .clk               (clk),
    .rst               (rst),
    .r_store_valid_i   (r_store_valid_i),
    .r_store_ready_o   (r_store_ready_o),
    .r_store_id_i      (r_store_id_i),
    .r_store_data_i    (r_store_data_i),
    .r_store_resp_i    (r_store_resp_i),
    .r_store_last_i    (r_store_last_i),
    .rm_release_uid    (rm_release_uid),
    .r_release_valid_o (r_release_valid_o),
    .r_release_ready_i (r_release_ready_i),
    .r_release_id_o    (r_release_id_o),
    .r_release_data_o  (r_release_data_o),
    .r_release_resp_o  (r_release_resp_o),
    .r_release_last_o  (r_release_last_o),
    .rm_error          (rm_error)
  );

  // Reference model: one FIFO of parked beats per uid.
  mbeat_t mq [256][$];
  int     total;
  bit     init_m;
  bit     err_m;
  int     vectors;
  int     miscompares;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit sv, input logic [31:0] sid, input logic [31:0] sdata,
                       input logic [1:0] sresp, input bit slast,
                       input logic [31:0] ruid, input bit rrdy);
    int     su, ru, after, first;
    bit     exp_rdy, exp_vld, sfire, rfire, has_last;
    mbeat_t hb, nb;
    @(negedge clk);
    r_store_valid_i   = sv;
    r_store_id_i      = sid;
    r_store_data_i    = sdata;
    r_store_resp_i    = sresp;
    r_store_last_i    = slast;
    rm_release_uid    = ruid;
    r_release_ready_i = rrdy;
    #1;
    su      = int'(sid[7:0]);
    ru      = int'(ruid[7:0]);
    exp_rdy = init_m && (total < POOL);
    exp_vld = (mq[ru].size() != 0);
    check("store_ready", 64'(r_store_ready_o), 64'(exp_rdy));
    check("release_valid", 64'(r_release_valid_o), 64'(exp_vld));
    if (exp_vld) begin
      hb = mq[ru][0];
      check("release_data", 64'(r_release_data_o), 64'(hb.data));
      check("release_resp", 64'(r_release_resp_o), 64'(hb.resp));
      check("release_last", 64'(r_release_last_o), 64'(hb.last));
      check("release_id", 64'(r_release_id_o), 64'(ruid));
    end
    check("rm_error", 64'(rm_error), 64'(err_m));
    sfire = sv && exp_rdy;
    rfire = exp_vld && rrdy;
    @(posedge clk);
`ifdef R_RM_PROTOCOL_CHECK_EN
    if (sfire) begin
      first    = (rfire && ru == su) ? 1 : 0;
      after    = mq[su].size() + 1 - first;
      has_last = 1'b0;
      for (int k = first; k < mq[su].size(); k++) if (mq[su][k].last) has_last = 1'b1;
      if (sid[31:8] != 24'd0 || after > MAXL || has_last) err_m = 1'b1;
    end
`endif
    if (rfire) begin
      void'(mq[ru].pop_front());
      total--;
    end
    if (sfire) begin
      nb.data = sdata;
      nb.resp = sresp;
      nb.last = slast;
      mq[su].push_back(nb);
      total++;
    end
    init_m = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'hFF, 1'b0);
  endtask

  task automatic do_reset(input logic [31:0] probe_uid);
    @(negedge clk);
    rst               = 1'b0;
    r_store_valid_i   = 1'b0;
    r_release_ready_i = 1'b0;
    rm_release_uid    = probe_uid;
    #1;
    for (int u = 0; u < 256; u++) mq[u].delete();
    total  = 0;
    init_m = 1'b0;
    err_m  = 1'b0;
    check("reset_ready", 64'(r_store_ready_o), 64'd0);
    check("reset_valid", 64'(r_release_valid_o), 64'd0);
    check("reset_error", 64'(rm_error), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic drain(input logic [31:0] uid);
    int guard;
    guard = 0;
    while (mq[uid[7:0]].size() != 0 && guard < 2 * MAXL + POOL) begin
      cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, uid, 1'b1);
      guard++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Four beats on one uid, then in-order release.
    do_reset(32'h23);
    idle(1);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h23, 32'hD0 + 32'(i), 2'(i), (i == 3), 32'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h23, 1'b1);

    // Interleaved uids released in reverse uid order.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, (i % 2 == 1) ? 32'h31 : 32'h10, 32'h1000 + 32'(i), 2'b00, (i >= 4), 32'h00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h31, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h10, 1'b1);

    // Fill the pool, then check there is no same-cycle bypass of a freed entry.
    for (int i = 0; i < POOL; i++)
      cycle(1'b1, 32'(i / 4), $urandom, 2'($urandom_range(0, 3)), (i % 4 == 3), 32'hFF, 1'b0);
    cycle(1'b1, 32'h3F, 32'hF00D, 2'b00, 1'b0, 32'hFF, 1'b0);
    cycle(1'b1, 32'h3F, 32'hF00D, 2'b00, 1'b0, 32'h00, 1'b1);
    cycle(1'b1, 32'h3F, 32'hF00D, 2'b00, 1'b0, 32'hFF, 1'b0);
    for (int u = 0; u < 16; u++) drain(32'(u));
    drain(32'h3F);
    cycle(1'b1, 32'h60, 32'hAA, 2'b00, 1'b1, 32'hFF, 1'b0);
    drain(32'h60);

    // Single-beat uid: release and store in the same cycle.
    cycle(1'b1, 32'h05, 32'h0505_0001, 2'b00, 1'b0, 32'hFF, 1'b0);
    cycle(1'b1, 32'h05, 32'h0505_0002, 2'b01, 1'b1, 32'h05, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h05, 1'b0);
    drain(32'h05);

    // Empty uid request with ready high.
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h77, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h1_0077, 1'b1);

    // Random traffic over a handful of uids, with a reset mid-burst.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] sid, ruid;
      sid  = 32'($urandom_range(0, 7)) << 4;
      ruid = 32'($urandom_range(0, 7)) << 4;
      if ($urandom_range(0, 31) == 0) sid[20] = 1'b1;
      if ($urandom_range(0, 7) == 0) ruid[16] = 1'b1;
      if (n == 200) begin
        do_reset(32'h30);
      end
      cycle($urandom_range(0, 9) < 6, sid, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 5) == 0, ruid, $urandom_range(0, 9) < 5);
    end

    // Nine beats to one uid: over-length error in checking builds, stays set.
    do_reset(32'h44);
    idle(1);
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 32'h44, 32'h4400 + 32'(i), 2'b00, 1'b0, 32'hFF, 1'b0);
    idle(3);
    drain(32'h44);
    idle(1);
    do_reset(32'h44);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
